pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline buffer for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries an opaque payload using valid/ready handshakes in place of a global stall vector.
//  Optional 2-entry skid removes the combinational ready path from downstream to upstream.
//  Flush (jump/branch redirect) empties the stage to a NOP bubble.
// PARAMETERS
//  DATA_W   160             payload width in bits (pc, rd, inst id/type, operands, imm, ...)
//  NOP_VAL  {DATA_W{1'b0}}  value on dn_data_out whenever the stage holds no valid entry
//  SKID_EN  1               1: 2-entry skid, registered ready; 0: single register, comb ready
// PORTS
//  clk_in        in   1       clock, rising edge
//  rst_in        in   1       reset, asynchronous, active-low
//  rdy_in        in   1       global ready; 0 freezes all state, no transfers
//  flush_in      in   1       discard all held entries and the incoming entry this cycle
//  up_valid_in   in   1       upstream entry valid
//  up_data_in    in   DATA_W  upstream payload
//  up_ready_out  out  1       stage accepts an entry this cycle
//  dn_valid_out  out  1       head entry valid
//  dn_data_out   out  DATA_W  head payload (NOP_VAL when dn_valid_out=0)
//  dn_ready_in   in   1       downstream accepts head this cycle
//  occ_out       out  2       number of held entries (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  - up_fire = rdy_in & up_valid_in & up_ready_out; dn_fire = rdy_in & dn_valid_out & dn_ready_in.
//  - Reset (rst_in=0, async): state EMPTY, dn_valid_out=0, dn_data_out=NOP_VAL, skid slot=NOP_VAL,
//    occ_out=0. Outputs stay at reset values until the first clk_in edge after rst_in rises.
//  - Latency: an accepted entry appears on dn_* the cycle after up_fire. No bypass.
//  - State machine (SKID_EN=1): EMPTY (occ 0), HALF (head valid), FULL (head + skid valid).
//    EMPTY: up_fire -> HALF, head<=up_data_in.
//    HALF : up_fire&dn_fire -> HALF, head<=up_data_in; up_fire&!dn_fire -> FULL, skid<=up_data_in;
//           !up_fire&dn_fire -> EMPTY, head<=NOP_VAL; neither -> HALF, hold.
//    FULL : dn_fire -> HALF, head<=skid, skid<=NOP_VAL; else hold. up_fire cannot occur.
//  - up_ready_out (SKID_EN=1) = rdy_in & (state!=FULL). Depends only on rdy_in and flops.
//  - SKID_EN=0: states EMPTY/HALF only. up_ready_out = rdy_in & (!dn_valid_out | dn_ready_in).
//    Simultaneous up_fire & dn_fire replaces the head. Skid storage is not generated.
//  - flush_in=1 & rdy_in=1: next state EMPTY, head and skid <= NOP_VAL, and any same-cycle up_fire
//    entry is dropped. Flush overrides every transition. A same-cycle dn_fire still counts as
//    a completed transfer for the consumer.
//  - rdy_in=0: no state, data or occupancy change, including when flush_in=1. Flush is not latched.
//  - Payload is never modified; ordering is strict FIFO; an entry is never duplicated or lost
//    except by flush.
//  - dn_data_out=NOP_VAL exactly when dn_valid_out=0 (bubble insertion, as with inserted NOPs).
// STRUCTURE
//  - Shared package pipe_pkg: stage state enum {ST_EMPTY, ST_HALF, ST_FULL}, occupancy width
//    constant, the canonical zero/NOP payload constants used by the CPU stages.
//  - Instance payload layouts (ID/EX struct, etc.) are defined in pipe_pkg, not here.
//  - One sub-module: pipe_slot (DATA_W register with load/clear and NOP_VAL reset),
//    instantiated for head and skid.
//  - Next-state/control logic stays in this module; generate on SKID_EN.
// TESTING
//  1. Reset mid-operation in FULL (rst_in=0 between edges) -> dn_valid_out=0, dn_data_out=NOP_VAL,
//     occ_out=0 immediately, with no clock edge needed.
//  2. Stream 0x1..0x8 with dn_ready_in=1 every cycle -> one output per cycle after 1-cycle latency,
//     order 0x1..0x8, up_ready_out constantly 1.
//  3. Push 0xA,0xB with dn_ready_in=0 -> occ_out=2, up_ready_out=0; raise dn_ready_in ->
//     0xA then 0xB out on consecutive cycles.
//  4. FULL with 0xA,0xB; assert flush_in with up_valid_in=1, data 0xC -> next cycle
//     occ_out=0 and dn_data_out=NOP_VAL; 0xC is never emitted.
//  5. rdy_in=0 for 3 cycles with up_valid_in=1, dn_ready_in=1, flush_in=1 -> dn_* and occ_out
//     unchanged, up_ready_out=0.
//  6. SKID_EN=0: HALF holding 0x5, dn_ready_in=1, up 0x6 same cycle -> next cycle head=0x6,
//     occ_out=1, 0x5 consumed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states, canonical NOP payloads
// and the inter-stage payload layouts used by the CPU stages.
package pipe_pkg;
   localparam int OCC_W       = 2;
   localparam int PIPE_DATA_W = 160;

   // Encoding doubles as the occupancy count.
   typedef enum logic [OCC_W-1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } stage_st_e;

   localparam logic [PIPE_DATA_W-1:0] PIPE_NOP    = '0;
   localparam logic [31:0]            RV_NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [7:0]  inst_id;
      logic [3:0]  inst_type;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] imm;
      logic [14:0] rsvd;
   } id_ex_t;

   function automatic logic [OCC_W-1:0] st_occ(input stage_st_e st);
      return OCC_W'(st);
   endfunction
endpackage

// File: rtl/pipe_slot.sv
// One payload register of a pipeline stage; clear wins over load and both
// reset and clear return it to the bubble value.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                DATA_W  = PIPE_DATA_W,
   parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (clear_i)
         data_d = NOP_VAL;
      else if (load_i)
         data_d = d_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         data_q <= NOP_VAL;
      else
         data_q <= data_d;
   end

   assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready inter-stage buffer with optional 2-entry skid and flush-to-bubble.
//   state    | meaning
//   ST_EMPTY | no entry held, dn_* shows the bubble
//   ST_HALF  | head valid, skid empty
//   ST_FULL  | head and skid valid, upstream blocked (skid build only)
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W  = PIPE_DATA_W,
   parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
   parameter int                SKID_EN = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              up_valid_in,
   input  logic [DATA_W-1:0] up_data_in,
   output logic              up_ready_out,
   output logic              dn_valid_out,
   output logic [DATA_W-1:0] dn_data_out,
   input  logic              dn_ready_in,
   output logic [OCC_W-1:0]  occ_out
);
   stage_st_e         state_q, state_d;
   logic              up_fire, dn_fire;
   logic              head_ld, head_clr, head_sel_skid, skid_ld, skid_clr;
   logic [DATA_W-1:0] head_q, skid_q, head_src;

   assign dn_valid_out = (state_q != ST_EMPTY);
   assign dn_data_out  = head_q;
   assign occ_out      = st_occ(state_q);
   assign up_fire      = rdy_in & up_valid_in & up_ready_out;
   assign dn_fire      = rdy_in & dn_valid_out & dn_ready_in;
   assign head_src     = head_sel_skid ? skid_q : up_data_in;

   always_comb begin
      state_d       = state_q;
      head_ld       = 1'b0;
      head_clr      = 1'b0;
      head_sel_skid = 1'b0;
      skid_ld       = 1'b0;
      skid_clr      = 1'b0;
      if (rdy_in) begin
         if (flush_in) begin
            state_d  = ST_EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
         end else begin
            case (state_q)
               ST_EMPTY: begin
                  if (up_fire) begin
                     state_d = ST_HALF;
                     head_ld = 1'b1;
                  end
               end
               ST_HALF: begin
                  // Without a skid, up_fire in HALF implies dn_fire: the head is replaced.
                  if (up_fire && (dn_fire || SKID_EN == 0)) begin
                     head_ld = 1'b1;
                  end else if (up_fire) begin
                     state_d = ST_FULL;
                     skid_ld = 1'b1;
                  end else if (dn_fire) begin
                     state_d  = ST_EMPTY;
                     head_clr = 1'b1;
                  end
               end
               ST_FULL: begin
                  if (dn_fire) begin
                     state_d       = ST_HALF;
                     head_ld       = 1'b1;
                     head_sel_skid = 1'b1;
                     skid_clr      = 1'b1;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_head (
      .clk_i   (clk_in),
      .rst_n_i (rst_in),
      .load_i  (head_ld),
      .clear_i (head_clr),
      .d_i     (head_src),
      .q_o     (head_q)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
            .clk_i   (clk_in),
            .rst_n_i (rst_in),
            .load_i  (skid_ld),
            .clear_i (skid_clr),
            .d_i     (up_data_in),
            .q_o     (skid_q)
         );
         // Registered ready: no combinational path from dn_ready_in.
         assign up_ready_out = rdy_in & (state_q != ST_FULL);
      end else begin : g_noskid
         assign skid_q       = NOP_VAL;
         assign up_ready_out = rdy_in & (!dn_valid_out | dn_ready_in);
      end
   endgenerate
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid build (dut) and single-register build (dut1).
module tb_pipe_stage_buf;
   localparam int DW = 160;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rdy = 1'b0, flush = 1'b0;
   logic          up_v = 1'b0, dn_r = 1'b0;
   logic [DW-1:0] up_d = '0;
   logic          up_rdy, dn_v;
   logic [DW-1:0] dn_d;
   logic [1:0]    occ;

   logic          up_v1 = 1'b0, dn_r1 = 1'b0;
   logic [DW-1:0] up_d1 = '0;
   logic          up_rdy1, dn_v1;
   logic [DW-1:0] dn_d1;
   logic [1:0]    occ1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .SKID_EN(1)) dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
      .up_valid_in(up_v), .up_data_in(up_d), .up_ready_out(up_rdy),
      .dn_valid_out(dn_v), .dn_data_out(dn_d), .dn_ready_in(dn_r), .occ_out(occ)
   );

   pipe_stage_buf #(.DATA_W(DW), .SKID_EN(0)) dut1 (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
      .up_valid_in(up_v1), .up_data_in(up_d1), .up_ready_out(up_rdy1),
      .dn_valid_out(dn_v1), .dn_data_out(dn_d1), .dn_ready_in(dn_r1), .occ_out(occ1)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      chk("rst_valid", DW'(dn_v), DW'(0));
      chk("rst_data",  dn_d, '0);
      chk("rst_occ",   DW'(occ), DW'(0));
      #9 rst_n = 1'b1;
      rdy = 1'b1;
      cyc();

      // streaming at full rate
      dn_r = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         up_v = 1'b1;
         up_d = DW'(i);
         #2 chk($sformatf("stream_rdy%0d", i), DW'(up_rdy), DW'(1));
         cyc();
         chk($sformatf("stream_v%0d", i), DW'(dn_v), DW'(1));
         chk($sformatf("stream_d%0d", i), dn_d, DW'(i));
      end
      up_v = 1'b0;
      cyc();
      chk("stream_drain_occ", DW'(occ), DW'(0));
      chk("stream_drain_nop", dn_d, '0);

      // fill skid, then drain in order
      dn_r = 1'b0;
      up_v = 1'b1; up_d = DW'('hA); cyc();
      up_d = DW'('hB); cyc();
      up_v = 1'b0;
      #2;
      chk("full_occ",  DW'(occ), DW'(2));
      chk("full_rdy",  DW'(up_rdy), DW'(0));
      chk("full_head", dn_d, DW'('hA));
      dn_r = 1'b1;
      cyc();
      chk("drain1_d", dn_d, DW'('hB));
      chk("drain1_occ", DW'(occ), DW'(1));
      cyc();
      chk("drain2_v", DW'(dn_v), DW'(0));
      chk("drain2_d", dn_d, '0);

      // flush from FULL drops held entries and the incoming one
      dn_r = 1'b0;
      up_v = 1'b1; up_d = DW'('hA); cyc();
      up_d = DW'('hB); cyc();
      flush = 1'b1; up_d = DW'('hC);
      cyc();
      flush = 1'b0; up_v = 1'b0;
      chk("flush_occ", DW'(occ), DW'(0));
      chk("flush_d",   dn_d, '0);
      dn_r = 1'b1;
      cyc();
      chk("flush_noC_v", DW'(dn_v), DW'(0));
      chk("flush_noC_d", dn_d, '0);

      // global freeze, flush not latched
      dn_r = 1'b0;
      up_v = 1'b1; up_d = DW'('hA); cyc();
      rdy = 1'b0; up_d = DW'('hD); dn_r = 1'b1; flush = 1'b1;
      #2 chk("frz_rdy", DW'(up_rdy), DW'(0));
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("frz_occ%0d", i), DW'(occ), DW'(1));
         chk($sformatf("frz_d%0d", i), dn_d, DW'('hA));
         chk($sformatf("frz_v%0d", i), DW'(dn_v), DW'(1));
      end
      rdy = 1'b1; flush = 1'b0; dn_r = 1'b0; up_d = DW'('hE);
      cyc();
      up_v = 1'b0;
      chk("unfrz_occ", DW'(occ), DW'(2));
      chk("unfrz_d",   dn_d, DW'('hA));

      // async reset while FULL, mid-cycle
      #2 rst_n = 1'b0;
      #1;
      chk("arst_v",   DW'(dn_v), DW'(0));
      chk("arst_d",   dn_d, '0);
      chk("arst_occ", DW'(occ), DW'(0));
      #1 rst_n = 1'b1;
      cyc();
      chk("post_rst_occ", DW'(occ), DW'(0));

      // single-register build: simultaneous fire replaces the head
      dn_r1 = 1'b0; up_v1 = 1'b1; up_d1 = DW'('h5);
      #2 chk("ns_rdy_empty", DW'(up_rdy1), DW'(1));
      cyc();
      up_v1 = 1'b0;
      #2;
      chk("ns_head5", dn_d1, DW'('h5));
      chk("ns_rdy_blk", DW'(up_rdy1), DW'(0));
      dn_r1 = 1'b1; up_v1 = 1'b1; up_d1 = DW'('h6);
      #1 chk("ns_rdy_pass", DW'(up_rdy1), DW'(1));
      cyc();
      up_v1 = 1'b0;
      chk("ns_head6", dn_d1, DW'('h6));
      chk("ns_occ1",  DW'(occ1), DW'(1));
      cyc();
      chk("ns_empty_occ", DW'(occ1), DW'(0));
      chk("ns_empty_d",   dn_d1, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
